// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline definitions for the ID/EX boundary:
// control bundle layout, FSM states and drain length.
package id_ex_stage_pkg;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_src;
    logic       reg_dst;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] jump;
    logic [5:0] opcode;
  } ctrl_t;

  localparam int N_BITS_CTRL   = $bits(ctrl_t);
  localparam int CTRL_MEM_READ = 11;
  localparam int DRAIN_CYCLES  = 3;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use detector: a load in EX whose target is read
// by the instruction currently in ID.
module hazard_detect #(
  parameter int N_BITS_REG = 5
) (
  input  logic                  ex_valid_i,
  input  logic                  ex_mem_read_i,
  input  logic [N_BITS_REG-1:0] ex_rt_i,
  input  logic [N_BITS_REG-1:0] id_rs_i,
  input  logic [N_BITS_REG-1:0] id_rt_i,
  output logic                  hazard_o
);

  logic hit;

  assign hit = (ex_rt_i == id_rs_i) |
               (ex_rt_i == id_rt_i);

  assign hazard_o = ex_valid_i &
                    ex_mem_read_i &
                    (ex_rt_i != '0) &
                    hit;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush, halt drain and
// optional load-use stall (build with HAZARD_DETECT_EN).
module id_ex_stage #(
  parameter int N_BITS      = 32,
  parameter int N_BITS_REG  = 5,
  parameter int N_BITS_CTRL = id_ex_stage_pkg::N_BITS_CTRL
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_valid,
  input  logic [N_BITS_CTRL-1:0] i_ctrl,
  input  logic                   i_flush,
  input  logic                   i_branch_taken,
  input  logic                   i_halt,
  input  logic [N_BITS-1:0]      i_pc,
  input  logic [N_BITS-1:0]      i_rs_data,
  input  logic [N_BITS-1:0]      i_rt_data,
  input  logic [N_BITS-1:0]      i_imm,
  input  logic [N_BITS_REG-1:0]  i_rs,
  input  logic [N_BITS_REG-1:0]  i_rt,
  input  logic [N_BITS_REG-1:0]  i_rd,
  output logic [N_BITS_CTRL-1:0] o_ctrl,
  output logic [N_BITS-1:0]      o_pc,
  output logic [N_BITS-1:0]      o_rs_data,
  output logic [N_BITS-1:0]      o_rt_data,
  output logic [N_BITS-1:0]      o_imm,
  output logic [N_BITS_REG-1:0]  o_rs,
  output logic [N_BITS_REG-1:0]  o_rt,
  output logic [N_BITS_REG-1:0]  o_rd,
  output logic                   o_valid,
  output logic                   o_stall,
  output logic                   o_halted
);

  import id_ex_stage_pkg::*;

  state_e state_q;
  logic [1:0] cnt_q;
  logic       halted_q;

  logic [N_BITS_CTRL-1:0] ctrl_q;
  logic [N_BITS-1:0]      pc_q, rs_data_q;
  logic [N_BITS-1:0]      rt_data_q, imm_q;
  logic [N_BITS_REG-1:0]  rs_q, rt_q, rd_q;
  logic                   valid_q;

  logic run, kill, ld_stall, bubble;

  assign run  = (state_q == ST_RUN);
  assign kill = i_flush | i_branch_taken;

`ifdef HAZARD_DETECT_EN
  logic hazard;

  hazard_detect #(
    .N_BITS_REG(N_BITS_REG)
  ) u_hazard_detect (
    .ex_valid_i   (valid_q),
    .ex_mem_read_i(ctrl_q[CTRL_MEM_READ]),
    .ex_rt_i      (rt_q),
    .id_rs_i      (i_rs),
    .id_rt_i      (i_rt),
    .hazard_o     (hazard)
  );

  // A flush kills the dependent instruction, so no stall.
  assign ld_stall = run & hazard & ~kill;
`else
  assign ld_stall = 1'b0;
`endif

  assign o_stall = ~run | ld_stall;
  assign bubble  = ~run | kill | i_halt | ld_stall;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= ST_RUN;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else if (i_valid) begin
      unique case (state_q)
        ST_RUN: begin
          if (i_halt) begin
            state_q <= ST_DRAIN;
            cnt_q   <= '0;
          end
        end
        ST_DRAIN: begin
          if (cnt_q == 2'(DRAIN_CYCLES - 1)) begin
            state_q  <= ST_HALTED;
            halted_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        ST_HALTED: begin
          halted_q <= 1'b1;
        end
        default: begin
          state_q  <= ST_RUN;
          cnt_q    <= '0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      ctrl_q    <= '0;
      pc_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      valid_q   <= 1'b0;
    end else if (i_valid) begin
      if (bubble) begin
        ctrl_q    <= '0;
        pc_q      <= '0;
        rs_data_q <= '0;
        rt_data_q <= '0;
        imm_q     <= '0;
        rs_q      <= '0;
        rt_q      <= '0;
        rd_q      <= '0;
        valid_q   <= 1'b0;
      end else begin
        ctrl_q    <= i_ctrl;
        pc_q      <= i_pc;
        rs_data_q <= i_rs_data;
        rt_data_q <= i_rt_data;
        imm_q     <= i_imm;
        rs_q      <= i_rs;
        rt_q      <= i_rt;
        rd_q      <= i_rd;
        valid_q   <= 1'b1;
      end
    end
  end

  assign o_ctrl    = ctrl_q;
  assign o_pc      = pc_q;
  assign o_rs_data = rs_data_q;
  assign o_rt_data = rt_data_q;
  assign o_imm     = imm_q;
  assign o_rs      = rs_q;
  assign o_rt      = rt_q;
  assign o_rd      = rd_q;
  assign o_valid   = valid_q;
  assign o_halted  = halted_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized bench for id_ex_stage against a
// cycle-level behavioural model.
module tb_id_ex_stage;

  import id_ex_stage_pkg::*;

  localparam int NB = 32;
  localparam int NR = 5;
  localparam int NC = N_BITS_CTRL;
`ifdef HAZARD_DETECT_EN
  localparam bit HD = 1'b1;
`else
  localparam bit HD = 1'b0;
`endif

  logic i_clk = 1'b0;
  logic i_reset = 1'b1;
  logic i_valid = 1'b0;
  logic i_flush = 1'b0;
  logic i_branch_taken = 1'b0;
  logic i_halt = 1'b0;
  logic [NC-1:0] i_ctrl = '0;
  logic [NB-1:0] i_pc = '0, i_rs_data = '0;
  logic [NB-1:0] i_rt_data = '0, i_imm = '0;
  logic [NR-1:0] i_rs = '0, i_rt = '0, i_rd = '0;

  logic [NC-1:0] o_ctrl;
  logic [NB-1:0] o_pc, o_rs_data, o_rt_data, o_imm;
  logic [NR-1:0] o_rs, o_rt, o_rd;
  logic o_valid, o_stall, o_halted;

  always #5 i_clk = ~i_clk;

  id_ex_stage #(
    .N_BITS(NB), .N_BITS_REG(NR), .N_BITS_CTRL(NC)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_valid(i_valid), .i_ctrl(i_ctrl),
    .i_flush(i_flush),
    .i_branch_taken(i_branch_taken),
    .i_halt(i_halt), .i_pc(i_pc),
    .i_rs_data(i_rs_data), .i_rt_data(i_rt_data),
    .i_imm(i_imm), .i_rs(i_rs), .i_rt(i_rt),
    .i_rd(i_rd), .o_ctrl(o_ctrl), .o_pc(o_pc),
    .o_rs_data(o_rs_data), .o_rt_data(o_rt_data),
    .o_imm(o_imm), .o_rs(o_rs), .o_rt(o_rt),
    .o_rd(o_rd), .o_valid(o_valid),
    .o_stall(o_stall), .o_halted(o_halted)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  // Model: mode plus number of stepped cycles since halt.
  typedef enum int {M_RUN, M_DRAIN, M_HALTED} mode_t;
  mode_t m_mode;
  int m_steps;
  logic [NC-1:0] e_ctrl;
  logic [NB-1:0] e_pc, e_rsd, e_rtd, e_imm;
  logic [NR-1:0] e_rs, e_rt, e_rd;
  logic e_valid;

  task automatic model_reset();
    m_mode = M_RUN; m_steps = 0;
    e_ctrl = '0; e_pc = '0; e_rsd = '0; e_rtd = '0;
    e_imm = '0; e_rs = '0; e_rt = '0; e_rd = '0;
    e_valid = 1'b0;
  endtask

  function automatic logic exp_stall();
    ctrl_t c;
    logic lu;
    c = ctrl_t'(e_ctrl);
    lu = HD && e_valid && c.mem_read && e_rt != 0 &&
         (e_rt == i_rs || e_rt == i_rt);
    return (m_mode != M_RUN) ||
           (lu && !i_flush && !i_branch_taken);
  endfunction

  task automatic model_step(input logic st);
    if (m_mode == M_RUN && !st && !i_flush &&
        !i_branch_taken && !i_halt) begin
      e_ctrl = i_ctrl; e_pc = i_pc;
      e_rsd = i_rs_data; e_rtd = i_rt_data;
      e_imm = i_imm; e_rs = i_rs; e_rt = i_rt;
      e_rd = i_rd; e_valid = 1'b1;
    end else begin
      e_ctrl = '0; e_pc = '0; e_rsd = '0; e_rtd = '0;
      e_imm = '0; e_rs = '0; e_rt = '0; e_rd = '0;
      e_valid = 1'b0;
    end
    if (m_mode == M_RUN) begin
      if (i_halt) begin
        m_mode = M_DRAIN;
        m_steps = 0;
      end
    end else if (m_mode == M_DRAIN) begin
      m_steps++;
      if (m_steps == DRAIN_CYCLES) m_mode = M_HALTED;
    end
  endtask

  task automatic chk_outs();
    chk("valid", o_valid, e_valid);
    chk("ctrl", o_ctrl, e_ctrl);
    chk("pc", o_pc, e_pc);
    chk("rs_data", o_rs_data, e_rsd);
    chk("rt_data", o_rt_data, e_rtd);
    chk("imm", o_imm, e_imm);
    chk("rs", o_rs, e_rs);
    chk("rt", o_rt, e_rt);
    chk("rd", o_rd, e_rd);
    chk("halted", o_halted, m_mode == M_HALTED);
  endtask

  task automatic tick();
    logic s;
    #1;
    s = exp_stall();
    chk("stall", o_stall, s);
    @(posedge i_clk);
    if (i_valid) model_step(s);
    #1;
    chk_outs();
  endtask

  // Reset asserted and released between clock edges.
  task automatic do_reset();
    #2 i_reset = 1'b0;
    #1;
    model_reset();
    chk_outs();
    chk("rst_stall", o_stall, 1'b0);
    #2 i_reset = 1'b1;
  endtask

  task automatic rand_in();
    i_ctrl = NC'($urandom);
    i_pc = $urandom; i_rs_data = $urandom;
    i_rt_data = $urandom; i_imm = $urandom;
    i_rs = NR'($urandom_range(0, 3));
    i_rt = NR'($urandom_range(0, 3));
    i_rd = NR'($urandom_range(0, 31));
  endtask

  task automatic set_ctrl(input logic ld,
                          input logic [5:0] op);
    ctrl_t c;
    c = '0;
    c.opcode = op;
    c.alu_src = 1'b1;
    c.reg_write = 1'b1;
    c.mem_read = ld;
    c.mem_to_reg = ld;
    i_ctrl = c;
  endtask

  initial begin
    int hc;
    model_reset();
    #1 i_reset = 1'b0;
    #1;
    chk_outs();
    chk("rst_stall", o_stall, 1'b0);
    @(negedge i_clk);
    i_reset = 1'b1;

    // addi
    i_valid = 1'b1;
    rand_in();
    set_ctrl(1'b0, 6'h08);
    i_rs = 5'd1; i_rd = 5'd2;
    tick();
    chk("addi_valid", o_valid, 1'b1);
    chk("addi_rd", o_rd, 5'd2);
    chk("addi_ctrl", o_ctrl, i_ctrl);

    // lw followed by dependent instruction
    set_ctrl(1'b1, 6'h23);
    i_rs = 5'd4; i_rt = 5'd3; i_rd = 5'd0;
    tick();
    set_ctrl(1'b0, 6'h08);
    i_rs = 5'd3; i_rt = 5'd5;
    #1 chk("lu_stall", o_stall, HD);
    tick();
    chk("lu_valid", o_valid, !HD);

    // lw with flush on the dependent cycle
    set_ctrl(1'b1, 6'h23);
    i_rs = 5'd4; i_rt = 5'd3;
    tick();
    set_ctrl(1'b0, 6'h08);
    i_rs = 5'd3; i_rt = 5'd5; i_flush = 1'b1;
    #1 chk("fl_stall", o_stall, 1'b0);
    tick();
    chk("fl_valid", o_valid, 1'b0);
    chk("fl_ctrl", o_ctrl, 0);
    i_flush = 1'b0;

    // halt and drain
    rand_in();
    i_halt = 1'b1;
    tick();
    chk("halt_bubble", o_valid, 1'b0);
    for (int k = 2; k <= 7; k++) begin
      rand_in();
      i_halt = 1'($urandom);
      i_flush = 1'($urandom);
      tick();
      chk("halted_edge", o_halted, k >= 4);
    end
    i_halt = 1'b0; i_flush = 1'b0;
    do_reset();

    // hold with i_valid low
    rand_in();
    tick();
    i_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      rand_in();
      tick();
    end
    i_valid = 1'b1;

    // reset in the middle of a drain
    i_halt = 1'b1;
    tick();
    i_halt = 1'b0;
    tick();
    do_reset();
    rand_in();
    tick();
    chk("post_rst_valid", o_valid, 1'b1);

    // random traffic
    hc = 0;
    for (int n = 0; n < 800; n++) begin
      rand_in();
      i_valid = ($urandom_range(0, 7) != 0);
      i_flush = ($urandom_range(0, 9) == 0);
      i_branch_taken = ($urandom_range(0, 9) == 0);
      i_halt = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 2) == 0) begin
        i_ctrl[CTRL_MEM_READ] = 1'b1;
      end
      tick();
      if (m_mode == M_HALTED) hc++;
      if (hc > 5 || $urandom_range(0, 99) == 0) begin
        do_reset();
        hc = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
